// File: rtl/flap_pulse.sv
// Push-button flap strobe: debounces press and release with a stable-sample
// counter and emits one enable-gated pulse per accepted press.
module flap_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             en,
  output logic             pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int unsigned DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE          = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic          accept_c;

  // A press is accepted on the edge that samples the last required stable 1.
  always_comb begin
    accept_c = 1'b0;
    if (button) begin
      if (state == IDLE && SINGLE)
        accept_c = 1'b1;
      else if (state == PRESS_WAIT && cnt == LAST)
        accept_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse     <= 1'b0;
      held      <= 1'b0;
      press_cnt <= '0;
    end else begin
      pulse <= accept_c & en;
      if (accept_c && en && press_cnt != '1)
        press_cnt <= press_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (button) begin
            cnt <= DW'(1);
            if (SINGLE) begin
              state <= HELD;
              held  <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (!button) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= HELD;
            held  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        HELD: begin
          if (!button) begin
            cnt <= DW'(1);
            if (SINGLE) begin
              state <= IDLE;
              held  <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
            end
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to HELD without producing a new press.
          if (button) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            held  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flap_pulse.sv
// Directed bench for flap_pulse: default build, a 2-bit counter build and a
// single-sample debounce build, all driven from shared inputs.
module tb_flap_pulse;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       en = 1'b1;
  logic       pulse, held;
  logic [7:0] press_cnt;
  logic       pulse2, held2;
  logic [1:0] press_cnt2;
  logic       pulse1, held1;
  logic [7:0] press_cnt1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  flap_pulse #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .button(button), .en(en),
    .pulse(pulse), .held(held), .press_cnt(press_cnt)
  );

  flap_pulse #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .button(button), .en(en),
    .pulse(pulse2), .held(held2), .press_cnt(press_cnt2)
  );

  flap_pulse #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .button(button), .en(en),
    .pulse(pulse1), .held(held1), .press_cnt(press_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; button = 1'b0; en = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({pulse, held, press_cnt} !== 10'd0)
      $display("FAIL reset_main: got %b want %b", {pulse, held, press_cnt}, 10'd0);
    else passed++;
    total++;
    if ({pulse2, held2, press_cnt2} !== 4'd0)
      $display("FAIL reset_cnt2: got %b want %b", {pulse2, held2, press_cnt2}, 4'd0);
    else passed++;
    total++;
    if ({pulse1, held1, press_cnt1} !== 10'd0)
      $display("FAIL reset_deb1: got %b want %b", {pulse1, held1, press_cnt1}, 10'd0);
    else passed++;
  endtask

  task automatic test_clean_press();
    logic [9:0] exp;
    reset = 1'b1; button = 1'b0; en = 1'b1;
    step();
    reset = 1'b0;
    button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = {1'(i == 4), 1'(i >= 4), 8'(i >= 4 ? 1 : 0)};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL clean_press cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
  endtask

  task automatic test_hold_bounce();
    logic [0:5] pat = 6'b001111;
    logic [9:0] exp;
    for (int i = 0; i < 6; i++) begin
      button = pat[i];
      step();
      exp = {1'b0, 1'b1, 8'd1};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL hold_bounce cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
    button = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = {1'b0, 1'(i < 4), 8'd1};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL release cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
  endtask

  task automatic test_bounce_press();
    logic [0:7] pat = 8'b11101111;
    logic [9:0] exp;
    reset = 1'b1; button = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      button = pat[i];
      step();
      exp = {1'(i == 7), 1'(i == 7), 8'(i == 7 ? 1 : 0)};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL bounce_press cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
    button = 1'b0;
    repeat (4) step();
    total++;
    if ({pulse, held, press_cnt} !== {1'b0, 1'b0, 8'd1})
      $display("FAIL bounce_release: got %b want %b", {pulse, held, press_cnt}, {1'b0, 1'b0, 8'd1});
    else passed++;
  endtask

  task automatic test_reset_mid_press();
    logic [9:0] exp;
    button = 1'b1;
    repeat (2) step();
    total++;
    if ({pulse, held, press_cnt} !== {1'b0, 1'b0, 8'd1})
      $display("FAIL pre_reset: got %b want %b", {pulse, held, press_cnt}, {1'b0, 1'b0, 8'd1});
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({pulse, held, press_cnt} !== 10'd0)
      $display("FAIL mid_press_reset: got %b want %b", {pulse, held, press_cnt}, 10'd0);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = {1'(i == 4), 1'(i == 4), 8'(i == 4 ? 1 : 0)};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL recount cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
    // Reset while the release is still being debounced.
    button = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    total++;
    if ({pulse, held, press_cnt} !== 10'd0)
      $display("FAIL mid_release_reset: got %b want %b", {pulse, held, press_cnt}, 10'd0);
    else passed++;
  endtask

  task automatic test_en_gate();
    logic [9:0] exp;
    reset = 1'b1; button = 1'b0;
    step();
    reset = 1'b0;
    en = 1'b0;
    button = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp = {1'b0, 1'(i >= 4), 8'd0};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL en_off cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({pulse, held, press_cnt} !== {1'b0, 1'b1, 8'd0})
        $display("FAIL en_late cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, {1'b0, 1'b1, 8'd0});
      else passed++;
    end
    button = 1'b0;
    repeat (4) step();
    button = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = {1'(i == 4), 1'(i == 4), 8'(i == 4 ? 1 : 0)};
      total++;
      if ({pulse, held, press_cnt} !== exp)
        $display("FAIL en_repress cyc %0d: got %b want %b", i, {pulse, held, press_cnt}, exp);
      else passed++;
    end
    button = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_saturate();
    logic [3:0] exp;
    int sat_now, sat_prev;
    reset = 1'b1; button = 1'b0; en = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sat_now  = (k > 3) ? 3 : k;
      sat_prev = (k - 1 > 3) ? 3 : k - 1;
      button = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        step();
        exp = {1'(i == 4), 1'(i == 4), 2'(i == 4 ? sat_now : sat_prev)};
        total++;
        if ({pulse2, held2, press_cnt2} !== exp)
          $display("FAIL sat press %0d cyc %0d: got %b want %b", k, i, {pulse2, held2, press_cnt2}, exp);
        else passed++;
      end
      button = 1'b0;
      for (int i = 1; i <= 5; i++) begin
        step();
        exp = {1'b0, 1'(i < 4), 2'(sat_now)};
        total++;
        if ({pulse2, held2, press_cnt2} !== exp)
          $display("FAIL sat release %0d cyc %0d: got %b want %b", k, i, {pulse2, held2, press_cnt2}, exp);
        else passed++;
      end
    end
    total++;
    if (press_cnt !== 8'd5)
      $display("FAIL wide_count: got %0d want 5", press_cnt);
    else passed++;
  endtask

  task automatic test_single();
    reset = 1'b1; button = 1'b0; en = 1'b1;
    step();
    reset = 1'b0;
    button = 1'b1;
    step();
    total++;
    if ({pulse1, held1, press_cnt1} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL single_press: got %b want %b", {pulse1, held1, press_cnt1}, {1'b1, 1'b1, 8'd1});
    else passed++;
    step();
    total++;
    if ({pulse1, held1, press_cnt1} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL single_hold: got %b want %b", {pulse1, held1, press_cnt1}, {1'b0, 1'b1, 8'd1});
    else passed++;
    button = 1'b0;
    step();
    total++;
    if ({pulse1, held1, press_cnt1} !== {1'b0, 1'b0, 8'd1})
      $display("FAIL single_release: got %b want %b", {pulse1, held1, press_cnt1}, {1'b0, 1'b0, 8'd1});
    else passed++;
    button = 1'b1;
    step();
    total++;
    if ({pulse1, held1, press_cnt1} !== {1'b1, 1'b1, 8'd2})
      $display("FAIL single_repress: got %b want %b", {pulse1, held1, press_cnt1}, {1'b1, 1'b1, 8'd2});
    else passed++;
  endtask

  initial begin
    step();
    test_reset();
    test_clean_press();
    test_hold_bounce();
    test_bounce_press();
    test_reset_mid_press();
    test_en_gate();
    test_saturate();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
